// File: rtl/regfile_lsu.sv
// regfile_lsu: NREGS x DATA_W register file with two combinational read ports,
// an ALU writeback port, an immediate/register move path and a load/store
// engine that talks to external RAM over a req/ack handshake with timeout.
module regfile_lsu #(
   parameter int  DATA_W  = 8,
   parameter int  NREGS   = 4,
   parameter int  IMM_W   = 4,
   parameter int  ADDR_W  = 8,
   parameter int  R0_INIT = 1,
   parameter int  TIMEOUT = 16,
   localparam int SEL_W   = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SEL_W-1:0]  rd_a_sel,
   output logic [DATA_W-1:0] rd_a_data,
   input  logic [SEL_W-1:0]  rd_b_sel,
   output logic [DATA_W-1:0] rd_b_data,
   input  logic              wr_en,
   input  logic [SEL_W-1:0]  wr_sel,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              mov_en,
   input  logic              mov_imm,
   input  logic [SEL_W-1:0]  mov_dst,
   input  logic [SEL_W-1:0]  mov_src,
   input  logic [IMM_W-1:0]  imm,
   input  logic              ls_start,
   input  logic              ls_store,
   input  logic [SEL_W-1:0]  ls_reg,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              ls_done,
   output logic              ls_err,
   output logic              hazard,
   output logic              wr_conflict
);

   // Timeout counter only needs to reach TIMEOUT-1; keep at least one bit.
   localparam bit            TO_EN   = (TIMEOUT > 0);
   localparam int            CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [DATA_W-1:0]   regs_r [NREGS];
   logic [ADDR_W-1:0]   addr_r;
   logic                we_r;
   logic [DATA_W-1:0]   wdata_r;
   logic [SEL_W-1:0]    dst_r;
   logic [CNT_W-1:0]    tcnt_r;
   logic                req_r;
   logic                busy_r;
   logic                done_r;
   logic                err_r;
   logic                conflict_r;

   logic                accept_s;
   logic                ack_s;
   logic                timeout_s;
   logic                load_wb_s;
   logic                wr_go_s;
   logic [SEL_W-1:0]    wr_idx_s;
   logic [DATA_W-1:0]   wr_val_s;
   logic                conflict_s;

   // Two's complement sign extension of the immediate to address width.
   function automatic logic [ADDR_W-1:0] sext_addr(input logic [IMM_W-1:0] v);
      sext_addr = ADDR_W'($signed(v));
   endfunction

   // Two's complement sign extension of the immediate to data width.
   function automatic logic [DATA_W-1:0] sext_data(input logic [IMM_W-1:0] v);
      sext_data = DATA_W'($signed(v));
   endfunction

   // Load/store FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Load/store FSM next state and per-cycle events (accept, ack, timeout).
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      ack_s       = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (ls_start) begin
               accept_s    = 1'b1;
               state_nxt_s = S_REQ;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               ack_s       = 1'b1;
               state_nxt_s = S_DONE;
            end else if (TO_EN && (tcnt_r == TO_LAST)) begin
               timeout_s   = 1'b1;
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_REQ;
            end
         end
         S_DONE: begin
            state_nxt_s = S_IDLE;
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // Transaction capture, handshake outputs, timeout counter and pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r     <= '0;
         we_r       <= 1'b0;
         wdata_r    <= '0;
         dst_r      <= '0;
         tcnt_r     <= '0;
         req_r      <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         conflict_r <= 1'b0;
      end else begin
         done_r     <= ack_s;
         err_r      <= timeout_s;
         conflict_r <= conflict_s;
         if (accept_s) begin
            addr_r <= sext_addr(imm);
            we_r   <= ls_store;
            if (ls_store) begin
               wdata_r <= regs_r[ls_reg];
            end else begin
               wdata_r <= wdata_r;
            end
            dst_r  <= ls_reg;
            tcnt_r <= '0;
            req_r  <= 1'b1;
            busy_r <= 1'b1;
         end else if (ack_s) begin
            req_r <= 1'b0;
         end else if (timeout_s) begin
            req_r  <= 1'b0;
            busy_r <= 1'b0;
         end else if (state_r == S_DONE) begin
            busy_r <= 1'b0;
         end else if (state_r == S_REQ) begin
            tcnt_r <= tcnt_r + CNT_W'(1);
         end else begin
            tcnt_r <= tcnt_r;
         end
      end
   end

   // Single write port arbitration: load writeback > ALU writeback > move.
   always_comb begin
      load_wb_s  = (state_r == S_REQ) && mem_ack && !we_r;
      wr_go_s    = 1'b0;
      wr_idx_s   = '0;
      wr_val_s   = '0;
      conflict_s = 1'b0;
      if (load_wb_s) begin
         wr_go_s    = 1'b1;
         wr_idx_s   = dst_r;
         wr_val_s   = mem_rdata;
         conflict_s = wr_en | mov_en;
      end else if (wr_en) begin
         wr_go_s    = 1'b1;
         wr_idx_s   = wr_sel;
         wr_val_s   = wr_data;
         conflict_s = mov_en;
      end else if (mov_en) begin
         wr_go_s  = 1'b1;
         wr_idx_s = mov_dst;
         if (mov_imm) begin
            wr_val_s = sext_data(imm);
         end else begin
            wr_val_s = regs_r[mov_src];
         end
      end else begin
         wr_go_s = 1'b0;
      end
   end

   // Register array; register 0 has a non-zero reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= (i == 0) ? DATA_W'(R0_INIT) : '0;
         end
      end else if (wr_go_s) begin
         regs_r[wr_idx_s] <= wr_val_s;
      end
   end

   assign rd_a_data   = regs_r[rd_a_sel];
   assign rd_b_data   = regs_r[rd_b_sel];
   assign mem_req     = req_r;
   assign mem_we      = we_r;
   assign mem_addr    = addr_r;
   assign mem_wdata   = wdata_r;
   assign busy        = busy_r;
   assign ls_done     = done_r;
   assign ls_err      = err_r;
   assign wr_conflict = conflict_r;
   assign hazard      = busy_r && !we_r && (state_r == S_REQ) &&
                        ((rd_a_sel == dst_r) || (rd_b_sel == dst_r));

endmodule

// File: tb/tb_regfile_lsu.sv
// Bench for regfile_lsu: directed test-plan scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model of the register file and load/store engine.
module tb_regfile_lsu;

   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] rd_a_sel = 2'd0, rd_b_sel = 2'd0;
   logic [7:0] rd_a_data, rd_b_data;
   logic       wr_en = 1'b0;
   logic [1:0] wr_sel = 2'd0;
   logic [7:0] wr_data = 8'h00;
   logic       mov_en = 1'b0, mov_imm = 1'b0;
   logic [1:0] mov_dst = 2'd0, mov_src = 2'd0;
   logic [3:0] imm = 4'h0;
   logic       ls_start = 1'b0, ls_store = 1'b0;
   logic [1:0] ls_reg = 2'd0;
   logic       mem_req, mem_we;
   logic [7:0] mem_addr, mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic       mem_ack = 1'b0;
   logic       busy, ls_done, ls_err, hazard, wr_conflict;

   regfile_lsu dut (
      .clk(clk), .rst_n(rst_n),
      .rd_a_sel(rd_a_sel), .rd_a_data(rd_a_data),
      .rd_b_sel(rd_b_sel), .rd_b_data(rd_b_data),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .mov_en(mov_en), .mov_imm(mov_imm), .mov_dst(mov_dst), .mov_src(mov_src),
      .imm(imm), .ls_start(ls_start), .ls_store(ls_store), .ls_reg(ls_reg),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .busy(busy), .ls_done(ls_done), .ls_err(ls_err), .hazard(hazard),
      .wr_conflict(wr_conflict)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Immediate as a signed number, wrapped to 8 bits.
   function automatic logic [7:0] sx(input logic [3:0] v);
      int s;
      s = int'(v);
      if (s > 7) s = s - 16;
      return 8'(s);
   endfunction

   // ---------------- reference model ----------------
   logic [7:0] m_regs [4];
   logic       m_req, m_busy, m_done, m_err, m_conf, m_we;
   logic [7:0] m_addr, m_wdata;
   logic [1:0] m_dst;
   int         m_wait;   // REQ cycles already spent without an ack

   // Model update: one transaction in flight, one register write per edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) m_regs[i] <= (i == 0) ? 8'h01 : 8'h00;
         m_req <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
         m_conf <= 1'b0; m_we <= 1'b0; m_addr <= 8'h00; m_wdata <= 8'h00;
         m_dst <= 2'd0; m_wait <= 0;
      end else begin
         m_done <= 1'b0;
         m_err  <= 1'b0;
         m_conf <= 1'b0;
         if (m_req && mem_ack && !m_we) begin
            m_regs[m_dst] <= mem_rdata;
            m_conf <= wr_en | mov_en;
         end else if (wr_en) begin
            m_regs[wr_sel] <= wr_data;
            m_conf <= mov_en;
         end else if (mov_en) begin
            m_regs[mov_dst] <= mov_imm ? sx(imm) : m_regs[mov_src];
         end
         if (m_req) begin
            if (mem_ack) begin
               m_req <= 1'b0; m_done <= 1'b1;
            end else if (m_wait + 1 == TMO) begin
               m_req <= 1'b0; m_busy <= 1'b0; m_err <= 1'b1;
            end else begin
               m_wait <= m_wait + 1;
            end
         end else if (m_done) begin
            m_busy <= 1'b0;
         end else if (!m_busy && ls_start) begin
            m_req <= 1'b1; m_busy <= 1'b1; m_wait <= 0;
            m_addr <= sx(imm); m_we <= ls_store; m_dst <= ls_reg;
            if (ls_store) m_wdata <= m_regs[ls_reg];
         end
      end
   end

   // Compare process: every output against the model, away from the edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rd_a_data", rd_a_data, m_regs[rd_a_sel]);
         chk("rd_b_data", rd_b_data, m_regs[rd_b_sel]);
         chk("mem_req", mem_req, m_req);
         chk("busy", busy, m_busy);
         chk("ls_done", ls_done, m_done);
         chk("ls_err", ls_err, m_err);
         chk("wr_conflict", wr_conflict, m_conf);
         chk("hazard", hazard, m_req && !m_we && (rd_a_sel == m_dst || rd_b_sel == m_dst));
         if (m_req) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      bit quiet;
      quiet = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;

      // Reset state
      for (int i = 0; i < 4; i++) begin
         rd_a_sel = 2'(i);
         #1 chk("reset_reg", rd_a_data, (i == 0) ? 32'h1 : 32'h0);
      end
      chk("reset_req", mem_req, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_addr", mem_addr, 8'h00);
      chk("reset_wdata", mem_wdata, 8'h00);

      // Writeback, immediate move, register move
      cyc();
      wr_en = 1'b1; wr_sel = 2'd2; wr_data = 8'h5A; rd_a_sel = 2'd2;
      #1 chk("no_bypass", rd_a_data, 8'h00);
      cyc(); wr_en = 1'b0;
      #1 chk("wr_r2", rd_a_data, 8'h5A);
      mov_en = 1'b1; mov_imm = 1'b1; mov_dst = 2'd1; imm = 4'hA;
      cyc(); mov_en = 1'b0; rd_a_sel = 2'd1;
      #1 chk("mov_imm_r1", rd_a_data, 8'hFA);
      chk("model_r1", m_regs[1], 8'hFA);
      mov_en = 1'b1; mov_imm = 1'b0; mov_dst = 2'd3; mov_src = 2'd2;
      cyc(); mov_en = 1'b0; rd_a_sel = 2'd3;
      #1 chk("mov_r3", rd_a_data, 8'h5A);

      // Load r1 <- mem[3], ack on second REQ cycle
      ls_start = 1'b1; ls_store = 1'b0; ls_reg = 2'd1; imm = 4'h3;
      cyc(); ls_start = 1'b0; rd_a_sel = 2'd1;
      #1 chk("ld_req", mem_req, 1'b1);
      chk("ld_addr", mem_addr, 8'h03);
      chk("ld_we", mem_we, 1'b0);
      chk("ld_hazard", hazard, 1'b1);
      cyc(); mem_ack = 1'b1; mem_rdata = 8'hC3;
      cyc(); mem_ack = 1'b0;
      #1 chk("ld_done", ls_done, 1'b1);
      chk("ld_req_drop", mem_req, 1'b0);
      chk("ld_busy_done", busy, 1'b1);
      chk("ld_r1", rd_a_data, 8'hC3);
      chk("model_ld_r1", m_regs[1], 8'hC3);
      cyc();
      #1 chk("ld_done_once", ls_done, 1'b0);
      chk("ld_idle", busy, 1'b0);

      // Store r0 to address sext(8), r0 rewritten during REQ
      ls_start = 1'b1; ls_store = 1'b1; ls_reg = 2'd0; imm = 4'h8;
      cyc(); ls_start = 1'b0;
      #1 chk("st_addr", mem_addr, 8'hF8);
      chk("st_we", mem_we, 1'b1);
      chk("st_wdata", mem_wdata, 8'h01);
      wr_en = 1'b1; wr_sel = 2'd0; wr_data = 8'h77;
      cyc(); wr_en = 1'b0; rd_b_sel = 2'd0;
      #1 chk("st_wdata_hold", mem_wdata, 8'h01);
      chk("r0_written", rd_b_data, 8'h77);
      mem_ack = 1'b1;
      cyc(); mem_ack = 1'b0;
      cyc();

      // Load to r2 with no ack: timeout
      ls_start = 1'b1; ls_store = 1'b0; ls_reg = 2'd2; imm = 4'h1;
      cyc(); ls_start = 1'b0;
      n = 0;
      while (mem_req && n < 40) begin
         n++;
         cyc();
      end
      chk("to_cycles", n, 16);
      chk("to_err", ls_err, 1'b1);
      chk("to_busy", busy, 1'b0);
      rd_a_sel = 2'd2;
      #1 chk("to_no_write", rd_a_data, 8'h5A);
      ls_start = 1'b1;
      cyc(); ls_start = 1'b0;
      #1 chk("restart", mem_req, 1'b1);
      mem_ack = 1'b1; mem_rdata = 8'h66;
      cyc(); mem_ack = 1'b0;
      cyc();

      // Load ack coincides with ALU write and move
      ls_start = 1'b1; ls_store = 1'b0; ls_reg = 2'd3; imm = 4'h0;
      cyc(); ls_start = 1'b0;
      mem_ack = 1'b1; mem_rdata = 8'hAB;
      wr_en = 1'b1; wr_sel = 2'd0; wr_data = 8'h22;
      mov_en = 1'b1; mov_imm = 1'b1; mov_dst = 2'd1; imm = 4'h5;
      cyc(); mem_ack = 1'b0; wr_en = 1'b0; mov_en = 1'b0;
      rd_a_sel = 2'd3; rd_b_sel = 2'd0;
      #1 chk("cf_flag", wr_conflict, 1'b1);
      chk("cf_load", rd_a_data, 8'hAB);
      chk("cf_alu_drop", rd_b_data, 8'h77);
      rd_a_sel = 2'd1;
      #1 chk("cf_mov_drop", rd_a_data, 8'hC3);
      cyc();
      #1 chk("cf_pulse", wr_conflict, 1'b0);

      // Reset in the middle of a REQ
      ls_start = 1'b1; ls_store = 1'b0; ls_reg = 2'd1; imm = 4'h2;
      cyc(); ls_start = 1'b0;
      #1 chk("rst_pre_req", mem_req, 1'b1);
      rst_n = 1'b0;
      #1 chk("rst_req", mem_req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rd_a_sel = 2'd1; rd_b_sel = 2'd0;
      #1 chk("rst_r1", rd_a_data, 8'h00);
      chk("rst_r0", rd_b_data, 8'h01);
      cyc(); rst_n = 1'b1;

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         cyc();
         if (c % 400 == 0) quiet = ($urandom % 3 == 0);
         rd_a_sel  = 2'($urandom);
         rd_b_sel  = 2'($urandom);
         wr_en     = ($urandom % 4 == 0);
         wr_sel    = 2'($urandom);
         wr_data   = 8'($urandom);
         mov_en    = ($urandom % 4 == 0);
         mov_imm   = 1'($urandom);
         mov_dst   = 2'($urandom);
         mov_src   = 2'($urandom);
         imm       = 4'($urandom);
         ls_start  = ($urandom % 3 == 0);
         ls_store  = 1'($urandom);
         ls_reg    = 2'($urandom);
         mem_ack   = !quiet && ($urandom % 3 == 0);
         mem_rdata = 8'($urandom);
         if (c == 2500) rst_n = 1'b0;
         if (c == 2502) rst_n = 1'b1;
      end
      cyc();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
